// File: rtl/udp_deglitch_delay.sv
// Clocked transport-delay line and minimum-pulse-width filter for a single-bit UDP flop output.
// Define UDP_DEGLITCH_STATS_EN to build the saturating rise/fall edge counters; otherwise they read 0.
module udp_deglitch_delay #(
    parameter int unsigned DELAY     = 3,
    parameter logic        INIT      = 1'b1,
    parameter int unsigned MIN_WIDTH = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             en,
    output logic             q_dly,
    output logic             q_filt,
    output logic             glitch,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt
);

    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $error("udp_deglitch_delay: DELAY=%0d outside 1..16", DELAY);
    end
    if (MIN_WIDTH < 1 || MIN_WIDTH > 15) begin : g_bad_min_width
        $error("udp_deglitch_delay: MIN_WIDTH=%0d outside 1..15", MIN_WIDTH);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("udp_deglitch_delay: CNT_W must be at least 1");
    end

    typedef enum logic {STABLE, PENDING} state_t;

    localparam logic [3:0] RUN_LAST = 4'(MIN_WIDTH - 1);

    state_t           state_q, state_d;
    logic [DELAY-1:0] dly_q, dly_d;
    logic [3:0]       run_q, run_d;
    logic             filt_q, filt_d;
    logic             glitch_q, glitch_d;
    logic             diff;
    logic             commit;

    // Case inequality so an X on d_in counts as a differing sample.
    assign diff = (d_in !== filt_q);

    always_comb begin
        dly_d = dly_q;
        if (en) begin
            dly_d[0] = d_in;
            for (int unsigned i = 1; i < DELAY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        filt_d   = filt_q;
        glitch_d = 1'b0;
        commit   = 1'b0;
        if (en) begin
            case (state_q)
                STABLE: begin
                    if (diff) begin
                        if (MIN_WIDTH == 1) begin
                            filt_d = d_in;
                            commit = 1'b1;
                        end else begin
                            state_d = PENDING;
                            run_d   = 4'd1;
                        end
                    end
                end
                PENDING: begin
                    if (diff) begin
                        if (run_q == RUN_LAST) begin
                            filt_d  = d_in;
                            commit  = 1'b1;
                            run_d   = '0;
                            state_d = STABLE;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        state_d  = STABLE;
                        run_d    = '0;
                        glitch_d = 1'b1;
                    end
                end
                default: begin
                    state_d = STABLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q    <= {DELAY{INIT}};
            state_q  <= STABLE;
            run_q    <= '0;
            filt_q   <= INIT;
            glitch_q <= 1'b0;
        end else begin
            dly_q    <= dly_d;
            state_q  <= state_d;
            run_q    <= run_d;
            filt_q   <= filt_d;
            glitch_q <= glitch_d;
        end
    end

    assign q_dly  = dly_q[DELAY-1];
    assign q_filt = filt_q;
    assign glitch = glitch_q;

`ifdef UDP_DEGLITCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else if (commit) begin
            if (d_in && rise_q != CNT_MAX) rise_q <= rise_q + CNT_W'(1);
            if (!d_in && fall_q != CNT_MAX) fall_q <= fall_q + CNT_W'(1);
        end
    end

    assign rise_cnt = rise_q;
    assign fall_cnt = fall_q;
`else
    logic stats_unused;
    assign stats_unused = commit;
    assign rise_cnt     = '0;
    assign fall_cnt     = '0;
`endif

endmodule

// File: tb/tb_udp_deglitch_delay.sv
// Scoreboard bench for udp_deglitch_delay: two instances (MIN_WIDTH 2/CNT_W 8 and MIN_WIDTH 3/CNT_W 2)
// share stimulus; a bench-side model pushes expected outputs, popped and compared after each edge.
module tb_udp_deglitch_delay;

    logic clk = 1'b0;
    logic rst_n;
    logic d_in;
    logic en;

    logic       qd_a, qf_a, gl_a;
    logic [7:0] rc_a, fc_a;
    logic       qd_b, qf_b, gl_b;
    logic [1:0] rc_b, fc_b;

    always #5 clk = ~clk;

    udp_deglitch_delay #(.DELAY(3), .INIT(1'b1), .MIN_WIDTH(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .en(en),
        .q_dly(qd_a), .q_filt(qf_a), .glitch(gl_a), .rise_cnt(rc_a), .fall_cnt(fc_a)
    );

    udp_deglitch_delay #(.DELAY(3), .INIT(1'b1), .MIN_WIDTH(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .en(en),
        .q_dly(qd_b), .q_filt(qf_b), .glitch(gl_b), .rise_cnt(rc_b), .fall_cnt(fc_b)
    );

`ifdef UDP_DEGLITCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [18:0] RST_A = {1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    localparam logic [6:0]  RST_B = {1'b1, 1'b1, 1'b0, 2'd0, 2'd0};

    logic [18:0] obs_a;
    logic [6:0]  obs_b;
    assign obs_a = {qd_a, qf_a, gl_a, rc_a, fc_a};
    assign obs_b = {qd_b, qf_b, gl_b, rc_b, fc_b};

    int n_vec = 0;
    int n_err = 0;

    logic [18:0] sb_a[$];
    logic [6:0]  sb_b[$];
    logic [18:0] exp_a;
    logic [6:0]  exp_b;

    logic m_dly[2][3];
    logic m_filt[2];
    logic m_gl[2];
    int   m_run[2];
    int   m_rc[2];
    int   m_fc[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 3; s++) m_dly[i][s] = 1'b1;
            m_filt[i] = 1'b1;
            m_gl[i]   = 1'b0;
            m_run[i]  = 0;
            m_rc[i]   = 0;
            m_fc[i]   = 0;
        end
    endtask

    // Apply one input pair, advance the model, queue the expected post-edge outputs, cross the edge.
    task automatic drive(input logic d, input logic e);
        d_in = d;
        en   = e;
        for (int i = 0; i < 2; i++) begin
            int mw;
            int cmax;
            mw   = (i == 0) ? 2 : 3;
            cmax = (i == 0) ? 255 : 3;
            m_gl[i] = 1'b0;
            if (e) begin
                m_dly[i][2] = m_dly[i][1];
                m_dly[i][1] = m_dly[i][0];
                m_dly[i][0] = d;
                if (d != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == mw) begin
                        m_filt[i] = d;
                        m_run[i]  = 0;
                        if (d) m_rc[i] = (m_rc[i] < cmax) ? m_rc[i] + 1 : cmax;
                        else   m_fc[i] = (m_fc[i] < cmax) ? m_fc[i] + 1 : cmax;
                    end
                end else begin
                    if (m_run[i] != 0) m_gl[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
        end
        sb_a.push_back({m_dly[0][2], m_filt[0], m_gl[0],
                        STATS ? 8'(m_rc[0]) : 8'd0, STATS ? 8'(m_fc[0]) : 8'd0});
        sb_b.push_back({m_dly[1][2], m_filt[1], m_gl[1],
                        STATS ? 2'(m_rc[1]) : 2'd0, STATS ? 2'(m_fc[1]) : 2'd0});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d_in  = 1'b0;
        en    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs_a !== RST_A) begin
            n_err++;
            $display("FAIL reset_hold_a: got %b expected %b", obs_a, RST_A);
        end
        n_vec++;
        if (obs_b !== RST_B) begin
            n_err++;
            $display("FAIL reset_hold_b: got %b expected %b", obs_b, RST_B);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1);
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec++;
            if (obs_a !== exp_a) begin
                n_err++;
                $display("FAIL reset_delay_a edge %0d: got %b expected %b", k + 1, obs_a, exp_a);
            end
            n_vec++;
            if (obs_b !== exp_b) begin
                n_err++;
                $display("FAIL reset_delay_b edge %0d: got %b expected %b", k + 1, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_glitch();
        logic [5:0] pat;
        pat = 6'b001100;
        for (int k = 5; k >= 0; k--) begin
            drive(pat[k], 1'b1);
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec++;
            if (obs_a !== exp_a) begin
                n_err++;
                $display("FAIL glitch_a step %0d: got %b expected %b", 5 - k, obs_a, exp_a);
            end
            n_vec++;
            if (obs_b !== exp_b) begin
                n_err++;
                $display("FAIL glitch_b step %0d: got %b expected %b", 5 - k, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_accept();
        logic [7:0] pat;
        pat = 8'b01110000;
        for (int k = 7; k >= 0; k--) begin
            drive(pat[k], 1'b1);
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec++;
            if (obs_a !== exp_a) begin
                n_err++;
                $display("FAIL accept_a step %0d: got %b expected %b", 7 - k, obs_a, exp_a);
            end
            n_vec++;
            if (obs_b !== exp_b) begin
                n_err++;
                $display("FAIL accept_b step %0d: got %b expected %b", 7 - k, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_freeze();
        logic [11:0] dpat;
        logic [11:0] epat;
        dpat = 12'b1_1_01010_1100;
        epat = 12'b1_1_00000_1111;
        for (int k = 11; k >= 0; k--) begin
            drive(dpat[k], epat[k]);
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec++;
            if (obs_a !== exp_a) begin
                n_err++;
                $display("FAIL freeze_a step %0d: got %b expected %b", 11 - k, obs_a, exp_a);
            end
            n_vec++;
            if (obs_b !== exp_b) begin
                n_err++;
                $display("FAIL freeze_b step %0d: got %b expected %b", 11 - k, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 6; k++) begin
                drive((k < 3) ? 1'b1 : 1'b0, 1'b1);
                exp_a = sb_a.pop_front();
                exp_b = sb_b.pop_front();
                n_vec++;
                if (obs_a !== exp_a) begin
                    n_err++;
                    $display("FAIL saturate_a pulse %0d step %0d: got %b expected %b", p, k, obs_a, exp_a);
                end
                n_vec++;
                if (obs_b !== exp_b) begin
                    n_err++;
                    $display("FAIL saturate_b pulse %0d step %0d: got %b expected %b", p, k, obs_b, exp_b);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] pat;
        drive(1'b0, 1'b1);
        void'(sb_a.pop_front());
        void'(sb_b.pop_front());
        drive(1'b1, 1'b1);
        void'(sb_a.pop_front());
        void'(sb_b.pop_front());
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs_a !== RST_A) begin
            n_err++;
            $display("FAIL async_reset_a: got %b expected %b", obs_a, RST_A);
        end
        n_vec++;
        if (obs_b !== RST_B) begin
            n_err++;
            $display("FAIL async_reset_b: got %b expected %b", obs_b, RST_B);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pat = 8'b11110000;
        for (int k = 7; k >= 0; k--) begin
            drive(pat[k], 1'b1);
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec++;
            if (obs_a !== exp_a) begin
                n_err++;
                $display("FAIL post_reset_a step %0d: got %b expected %b", 7 - k, obs_a, exp_a);
            end
            n_vec++;
            if (obs_b !== exp_b) begin
                n_err++;
                $display("FAIL post_reset_b step %0d: got %b expected %b", 7 - k, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
            exp_a = sb_a.pop_front();
            exp_b = sb_b.pop_front();
            n_vec++;
            if (obs_a !== exp_a) begin
                n_err++;
                $display("FAIL random_a step %0d: got %b expected %b", k, obs_a, exp_a);
            end
            n_vec++;
            if (obs_b !== exp_b) begin
                n_err++;
                $display("FAIL random_b step %0d: got %b expected %b", k, obs_b, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_accept();
        test_freeze();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/udp_deglitch_delay.md
Name: udp_deglitch_delay

Overview:
- Downstream consumer of a single-bit edge-triggered UDP flip-flop output, such as a clocked D flop with initial q=1.
- Provides two things:
  - a cycle-accurate, clocked replacement for a `buf #N` transport delay;
  - a minimum-pulse-width filter that rejects and flags short pulses.
- Counts committed edges so regression benches can check sequential-UDP output activity without `#` delays.

Parameters:
- DELAY, 3, cycles of delay from d_in to q_dly; legal 1..16.
- INIT, 1'b1, reset value of every delay stage and of q_filt. Matches the UDP initial statement.
- MIN_WIDTH, 2, consecutive differing samples needed before q_filt follows d_in; legal 1..15.
- CNT_W, 8, width of the edge counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- d_in  input  1  output of the upstream UDP flop.
- en  input  1  advance enable; 0 freezes all state.
- q_dly  output  1  d_in delayed by exactly DELAY enabled cycles.
- q_filt  output  1  width-filtered d_in.
- glitch  output  1  one-cycle pulse when a short pulse is rejected.
- rise_cnt  output  CNT_W  count of committed q_filt 0->1 transitions.
- fall_cnt  output  CNT_W  count of committed q_filt 1->0 transitions.

Behaviour:
- Reset:
  - rst_n low asynchronously forces:
    - all delay stages = INIT, so q_dly = INIT;
    - q_filt = INIT;
    - FSM = STABLE, run counter = 0;
    - glitch = 0;
    - rise_cnt = fall_cnt = 0.
  - Deassertion takes effect at the next rising clk.
  - Reset mid-pulse discards the pending pulse with no glitch flag.
- en=0: no state changes at all. Delay line, FSM, run counter and counters hold; glitch is 0 while en=0.
- Delay line:
  - DELAY-deep shift register; stage0 <= d_in on each enabled edge.
  - q_dly = last stage.
  - A d_in change sampled at enabled edge k appears on q_dly after enabled edge k+DELAY-1.
  - First DELAY-1 enabled cycles after reset output INIT.
- Filter FSM, evaluated on enabled edges only:
  - STABLE:
    - d_in == q_filt -> stay.
    - d_in != q_filt and MIN_WIDTH == 1 -> q_filt <= d_in, stay STABLE.
    - d_in != q_filt and MIN_WIDTH > 1 -> PENDING, run <= 1.
  - PENDING, d_in != q_filt:
    - run == MIN_WIDTH-1 -> q_filt <= d_in, run <= 0, STABLE.
    - otherwise run <= run+1.
  - PENDING, d_in == q_filt -> STABLE, run <= 0, glitch <= 1 for exactly one cycle.
  - glitch is registered and 0 in every other cycle.
  - Net effect: q_filt changes on the edge that samples the MIN_WIDTH-th consecutive differing value.
- Counters:
  - rise_cnt increments on the edge q_filt commits 0->1.
  - fall_cnt increments on the edge q_filt commits 1->0.
  - Both saturate at 2^CNT_W-1; no wrap.
- Illegal parameter values are caught by an elaboration-time check that calls $error.
- X on d_in is treated as a differing value. Benches drive only 0/1.

Optional Feature:
- Macro: UDP_DEGLITCH_STATS_EN.
- Defined: rise_cnt/fall_cnt are implemented as specified.
- Undefined:
  - No counter flops are built.
  - rise_cnt and fall_cnt are tied to constant 0.
  - Ports remain present, so instantiation is unchanged.
  - q_dly, q_filt and glitch are unaffected.

Test Plan:
- Reset/delay (DELAY=3, INIT=1): hold rst_n=0, d_in=0, then release with en=1.
  - Expect q_dly=1 for the first 2 post-reset edges.
  - Expect q_dly=0 after the 3rd.
  - Expect q_filt=0 after the 2nd edge (MIN_WIDTH=2).
  - Expect fall_cnt=1.
- Glitch rejection (MIN_WIDTH=3, q_filt=0): d_in=1 for 2 cycles, then 0.
  - Expect q_filt to stay 0.
  - Expect glitch=1 for exactly one cycle, on the edge sampling the return to 0.
  - Expect rise_cnt unchanged.
- Accept boundary (MIN_WIDTH=3): d_in=1 for exactly 3 cycles.
  - Expect q_filt=1 after the 3rd edge.
  - Expect glitch=0 and rise_cnt +1.
- Freeze: drop en for 5 cycles while toggling d_in.
  - Expect q_dly, q_filt, counters and FSM unchanged.
  - On en=1 again, delay resumes counting from the frozen contents.
- Saturation (CNT_W=2): 5 accepted rising edges.
  - Expect rise_cnt=3, held.
  - Without UDP_DEGLITCH_STATS_EN, expect rise_cnt=fall_cnt=0 throughout.
- Async reset mid-PENDING: assert rst_n low between clock edges.
  - Expect immediate q_dly=q_filt=1 and counters=0.
  - Expect no glitch pulse after release.
